// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier and its bench.
// Holds the FSM state encoding and the default operand width.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// WIDTH iterations per operation, registered product with a one-cycle done pulse.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] producto,
  output logic               busy,
  output logic               done
);

  localparam int ACC_W = 2 * WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t          state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   producto_reg, producto_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     acc_shift;

  // Datapath and FSM share a single register process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      producto_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      producto_reg <= producto_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    producto_next = producto_reg;
    // Partial product lands in the upper half; the extra MSB keeps the carry.
    acc_sum       = mplier_reg[0] ? (acc_reg + (ACC_W'(mcand_reg) << WIDTH)) : acc_reg;
    acc_shift     = acc_sum >> 1;

    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next  = a;
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = CALC;
        end
      end
      CALC: begin
        acc_next    = acc_shift;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          producto_next = acc_shift[2*WIDTH-1:0];
          state_next    = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == CALC);
    done_next = (state_next == DONE);
  end

  assign producto = producto_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench: products are checked against a*b of the
// operands logged at each accept edge, plus timing and reset behaviour.
module tb_shift_add_multiplier;
  import shift_add_multiplier_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int LOG_DEPTH = 4096;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] producto;
  logic           busy;
  logic           done;

  bit clk_en;
  int n_compared;
  int n_mismatched;

  // Operand log indexed by rising-edge number
  logic [W-1:0] a_at [LOG_DEPTH];
  logic [W-1:0] b_at [LOG_DEPTH];
  logic         start_at [LOG_DEPTH];
  int cyc;

  int  done_count;
  int  last_done;
  bit  b2b;
  int  busy_run;
  bit  prev_done;
  logic [2*W-1:0] prev_prod;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .producto (producto),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (cyc < LOG_DEPTH) begin
      a_at[cyc]     = a;
      b_at[cyc]     = b;
      start_at[cyc] = start;
    end
    cyc = cyc + 1;
  end

  // Monitor: every done pulse is checked against the operands of its accept edge.
  always @(negedge clk) begin
    int e0;
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
      prev_prod = producto;
    end else begin
      if (producto !== prev_prod) check("prod_changes_only_at_done", 32'(done), 32'd1);
      if (done) begin
        done_count++;
        e0 = cyc - 1 - W;
        check("done_one_cycle", 32'(prev_done), 32'd0);
        check("busy_low_in_done", 32'(busy), 32'd0);
        if (e0 >= 0 && e0 < LOG_DEPTH) begin
          check("accept_edge_had_start", 32'(start_at[e0]), 32'd1);
          check("prod_ref", 32'(producto), 32'(a_at[e0]) * 32'(b_at[e0]));
        end
        if (b2b && last_done >= 0) check("b2b_period", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
      end
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) check("busy_len", 32'(busy_run), 32'(W));
        busy_run = 0;
      end
      prev_done = done;
      prev_prod = producto;
    end
  end

  // Caller is at a negedge; start is presented for the next rising edge.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input bit disturb);
    int d0;
    d0    = done_count;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      start = disturb ? ((k == 1) || ($urandom_range(0, 1) == 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < W + 2; k++) @(negedge clk);
    check("done_pulses_per_op", 32'(done_count - d0), 32'd1);
    check("prod_final", 32'(producto), 32'(op_a) * 32'(op_b));
    $display("op a=%0d b=%0d disturb=%0d producto=%0d", op_a, op_b, disturb, producto);
  endtask

  initial begin
    int d0;
    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    done_count   = 0;
    last_done    = -1;
    b2b          = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    a            = '0;
    b            = '0;
    clk_en       = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_producto", 32'(producto), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(W'(15), W'(15), 1'b0);
    do_op(W'(12), W'(10), 1'b0);
    do_op(W'(0),  W'(9),  1'b0);
    do_op(W'(9),  W'(0),  1'b0);
    do_op(W'(7),  W'(6),  1'b1);

    for (int i = 0; i < 20; i++) do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // Back-to-back with start held and operands changing every cycle.
    d0        = done_count;
    last_done = -1;
    b2b       = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    b2b = 1'b0;
    check("b2b_done_count", 32'(done_count - d0), 32'd7);
    $display("b2b done pulses=%0d", done_count - d0);

    // Reset in the second CALC cycle aborts the operation.
    a = W'(13); b = W'(11); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d0 = done_count;
    rst_n = 1'b0;
    #1;
    check("abort_producto", 32'(producto), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W + 2) @(negedge clk);
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    check("abort_producto_held", 32'(producto), 32'd0);
    $display("abort test producto=%0d", producto);
    do_op(W'(13), W'(11), 1'b0);

    // Reset with the clock stopped mid-CALC must act immediately.
    a = W'(15); b = W'(15); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_producto", 32'(producto), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    $display("async reset producto=%0d busy=%0d done=%0d", producto, busy, done);
    #20;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(W'(5), W'(3), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; product width is 2*WIDTH (8 at default, matching the 8-bit binary input of the BCD conversion stage downstream).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-006 SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-007 SHALL have port producto, output, 2*WIDTH bits: registered unsigned product of the last completed operation.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 In IDLE with start=1 at rising edge E0, SHALL capture a and b into internal registers, clear the accumulator, clear the iteration counter, and enter CALC.
REQ-012 In IDLE with start=0, SHALL remain in IDLE and hold producto.
REQ-013 In CALC, SHALL perform one shift-add iteration per edge: when multiplier LSB=1, add multiplicand into the upper accumulator half with carry kept; then shift {carry, accumulator} right by one; then shift the multiplier right by one.
REQ-014 Accumulator arithmetic SHALL be 2*WIDTH+1 bits wide so no carry is lost; the result SHALL be exact for all operand pairs (max (2^WIDTH-1)^2).
REQ-015 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits; CALC SHALL last exactly WIDTH edges (E1..E_WIDTH).
REQ-016 At edge E_WIDTH, SHALL load producto with the final accumulator value and enter DONE.
REQ-017 done SHALL be 1 exactly during the DONE cycle (from E_WIDTH to E_WIDTH+1) and 0 otherwise.
REQ-018 busy SHALL be 1 exactly while in CALC; it SHALL be 0 in IDLE and DONE.
REQ-019 DONE SHALL unconditionally return to IDLE at the next edge; start in DONE SHALL be ignored.
REQ-020 start during CALC SHALL be ignored; changes on a or b after E0 SHALL NOT affect the result.
REQ-021 With start held high, operations SHALL repeat back-to-back with a period of WIDTH+2 cycles.
REQ-022 producto SHALL change only at the DONE-entry edge or on reset, giving the BCD stage a stable value between operations.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, producto=0, busy=0, done=0, and clear the accumulator, counter and operand registers.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.
REQ-025 Release of rst_n SHALL take effect at the first rising clk edge after deassertion; no operation starts on the release edge unless start=1 at that edge.

Structure
REQ-026 FSM state encodings (IDLE, CALC, DONE) and the default WIDTH constant SHALL live in a shared multiplier package used by this block and its bench.
REQ-027 SHALL be a single module with no sub-module; datapath and FSM SHALL share one sequential process plus combinational next-state logic.

Verification
REQ-028 Reset: rst_n=0 with clk stopped -> producto=0, busy=0, done=0 immediately.
REQ-029 a=15, b=15, start pulsed one cycle -> busy high 4 cycles, then done=1 for one cycle with producto=225 (8'hE1).
REQ-030 a=12, b=10 -> producto=120; then a=0, b=9 -> producto=0; a=9, b=0 -> producto=0; each with a single done pulse.
REQ-031 start held high, operands changed every cycle -> done pulses every 6 cycles; each producto equals the product of the operands sampled at the matching accept edge.
REQ-032 start pulsed during CALC, and a/b changed during CALC -> no restart and result unchanged (a=7, b=6 -> 42).
REQ-033 rst_n asserted at second CALC cycle of a=13, b=11 -> no done pulse, producto=0; next start with a=13, b=11 -> producto=143.
